// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter, 8N/8E + 1..2 stop bits; optional parity via UART_TX_PARITY_EN
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          txd,
    output logic                          busy
);

    localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CNT_W    = $clog2(STOP_LEN);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;
    logic             r_overflow;
    logic [LVL_W-1:0] w_level_next;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head;

    // Serializer state
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_bit;
    logic [2:0]       w_bit_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic             r_txd;
    logic             w_txd_next;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
    logic             w_parity_next;
`endif

    // A write is only taken when the registered full flag is clear.
    assign w_push = wr_en & ~r_full;
    assign w_head = r_mem[r_rd_ptr];

    // Next occupancy: simultaneous push and pop leave the level unchanged.
    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // Byte storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; full and overflow are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level    <= w_level_next;
            r_full     <= (w_level_next == LVL_FULL);
            r_overflow <= wr_en & r_full;
        end
    end

    // Next-state and next-datapath values; txd is derived from where the FSM is heading so it can be registered.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_txd_next   = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (r_level != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = ^w_head;
`endif
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next   = '0;
                    w_bit_next   = 3'd0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == STOP_LAST) begin
                    w_cnt_next = '0;
                    if (r_level != '0) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
`ifdef UART_TX_PARITY_EN
                        w_parity_next = ^w_head;
`endif
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase

        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_next = w_parity_next;
`endif
            default:  w_txd_next = 1'b1;
        endcase
    end

    // Serializer registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= 3'd0;
            r_shift  <= 8'h00;
            r_txd    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_txd    <= w_txd_next;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    assign full     = r_full;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign txd      = r_txd;
    assign busy     = (r_state != S_IDLE);

endmodule
